// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of a shared combinational ALU.
//               Grants one request, registers its operands toward the ALU,
//               captures the ALU result and holds it until acknowledged.
//               Optional macro ALU_ARB_FIXED_PRI_EN selects fixed priority
//               (requester 0 wins ties) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OPRN_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic [DATA_W-1:0] OP1_0,
    input  logic [DATA_W-1:0] OP2_0,
    input  logic [DATA_W-1:0] OP1_1,
    input  logic [DATA_W-1:0] OP2_1,
    input  logic [OPRN_W-1:0] OPRN_0,
    input  logic [OPRN_W-1:0] OPRN_1,
    input  logic              ACK,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic              ALU_ZERO,
    output logic [DATA_W-1:0] ALU_OP1,
    output logic [DATA_W-1:0] ALU_OP2,
    output logic [OPRN_W-1:0] ALU_OPRN,
    output logic              GNT0,
    output logic              GNT1,
    output logic [DATA_W-1:0] RES,
    output logic              RES_ZERO,
    output logic              RES_VALID,
    output logic              RES_ID
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_any_req;
    logic w_winner;   // 0 -> requester 0, 1 -> requester 1
    logic w_grant;
    logic w_capture;
    logic w_release;

    assign w_any_req = REQ0 | REQ1;

`ifdef ALU_ARB_FIXED_PRI_EN
    always_comb begin
        w_winner = REQ0 ? 1'b0 : 1'b1;
    end
`else
    // Index of the requester granted most recently; resets to 1 so that
    // requester 0 wins the first tie.
    logic r_last;

    always_comb begin
        if (REQ0 && REQ1) begin
            w_winner = ~r_last;
        end else begin
            w_winner = ~REQ0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_winner;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (ACK) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // GNT pulses last exactly the EXEC cycle because w_grant is only ever
    // raised for a single IDLE cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            GNT0 <= 1'b0;
            GNT1 <= 1'b0;
        end else begin
            GNT0 <= w_grant & ~w_winner;
            GNT1 <= w_grant &  w_winner;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_OP1  <= '0;
            ALU_OP2  <= '0;
            ALU_OPRN <= '0;
            RES_ID   <= 1'b0;
        end else if (w_grant) begin
            ALU_OP1  <= w_winner ? OP1_1  : OP1_0;
            ALU_OP2  <= w_winner ? OP2_1  : OP2_0;
            ALU_OPRN <= w_winner ? OPRN_1 : OPRN_0;
            RES_ID   <= w_winner;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RES       <= '0;
            RES_ZERO  <= 1'b0;
            RES_VALID <= 1'b0;
        end else begin
            if (w_capture) begin
                RES       <= ALU_OUT;
                RES_ZERO  <= ALU_ZERO;
                RES_VALID <= 1'b1;
            end else if (w_release) begin
                RES_VALID <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter OPRN_W, default 6, ALU operation code width.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 REQ0, REQ1  input  1 each  request from requester 0/1; held high with operands stable until GNTn.
REQ-006 OP1_0, OP2_0, OP1_1, OP2_1  input  DATA_W each  per-requester operands.
REQ-007 OPRN_0, OPRN_1  input  OPRN_W each  per-requester ALU operation code.
REQ-008 ACK  input  1  consumer of the result accepts it while RES_VALID=1.
REQ-009 ALU_OUT  input  DATA_W, and ALU_ZERO  input  1: combinational result and zero flag returned by the shared ALU.
REQ-010 ALU_OP1, ALU_OP2  output  DATA_W, and ALU_OPRN  output  OPRN_W: registered operands driven to the shared ALU.
REQ-011 GNT0, GNT1  output  1 each  one-cycle grant pulse; operands captured.
REQ-012 RES  output  DATA_W  registered result; RES_ZERO  output  1  registered zero flag.
REQ-013 RES_VALID  output  1  result valid; RES_ID  output  1  index of requester owning RES.

Function
REQ-014 FSM states IDLE, EXEC, DONE; exactly one active at a time.
REQ-015 IDLE: when REQ0|REQ1 sampled high, arbitrate, load winner's OP1/OP2/OPRN into ALU_OP1/ALU_OP2/ALU_OPRN, set GNTn=1 for the next cycle only, set RES_ID=winner, go EXEC.
REQ-016 IDLE with no request: stay IDLE, ALU_* registers hold previous values.
REQ-017 EXEC: capture ALU_OUT into RES and ALU_ZERO into RES_ZERO, set RES_VALID=1, go DONE; EXEC lasts exactly one cycle.
REQ-018 Latency: request sampled at edge N -> GNT high cycle N..N+1, RES_VALID high from edge N+1 (two edges request-to-result).
REQ-019 DONE: RES, RES_ZERO, RES_ID, RES_VALID held stable until ACK sampled high; then RES_VALID=0, go IDLE; new requests not sampled in DONE or EXEC.
REQ-020 ACK outside DONE ignored; ACK in same edge as entering DONE has no effect (RES_VALID not yet high).
REQ-021 Round-robin: single request wins outright; both requesting -> requester not granted last wins; LAST pointer updated on every grant.
REQ-022 GNT0 and GNT1 never high simultaneously; GNT only asserted in cycle following an IDLE arbitration.
REQ-023 OPRN forwarded unmodified; undefined codes (0x0, 0xA-0x3F) still execute, RES takes whatever ALU_OUT returns.
REQ-024 Requester deasserting REQ before GNT loses its slot without error.

Reset
REQ-025 RST low asynchronously forces: state IDLE, GNT0=GNT1=0, RES_VALID=0, RES=0, RES_ZERO=0, RES_ID=0, ALU_OP1=ALU_OP2=0, ALU_OPRN=0, LAST=1 (requester 0 wins first tie).
REQ-026 Reset during EXEC or DONE aborts the operation; result discarded, no GNT or RES_VALID after release until a new request.
REQ-027 First arbitration occurs on first rising edge with RST high.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRI_EN: defined -> fixed priority, requester 0 always wins ties, LAST unused; undefined -> round-robin per REQ-021.

Verification
REQ-029 REQ0 only, OP1_0=5, OP2_0=7, OPRN_0=0x1 -> GNT0 one cycle, RES=12, RES_ZERO=0, RES_ID=0, RES_VALID two edges after request.
REQ-030 REQ1 only, OP1_1=9, OP2_1=9, OPRN_1=0x2 -> RES=0, RES_ZERO=1, RES_ID=1.
REQ-031 REQ0 and REQ1 held high continuously with immediate ACK -> grants alternate 0,1,0,1 from reset (macro undefined); with ALU_ARB_FIXED_PRI_EN, GNT0 every time.
REQ-032 Result 0x00000003 (OPRN 0x3, 3x1), ACK held low 5 cycles -> RES, RES_ID, RES_VALID stable all 5 cycles; REQ1 asserted meanwhile gets no GNT until one edge after ACK.
REQ-033 RST pulsed low mid-EXEC -> all outputs 0 immediately (asynchronous), no RES_VALID after release until new REQ; next tie goes to requester 0.
REQ-034 REQ0 dropped before GNT while REQ1 high -> GNT1 only, GNT0 never asserted.
